evaluar_tablero: RTL and testbench

Sequential board evaluator for the tic-tac-toe controller: the read-side counterpart of the move-validation logic that writes player IDs into the nine board cell registers. On an `evaluate` request it walks the eight winning lines through a single-cell read port, one cell per cycle. It then reports winner, winning line, or draw to the game state machine with a one-cycle `done` pulse.

---
 rtl/tablero_pkg.sv | 36 +++
 rtl/tablero_line_rom.sv | 17 +
 rtl/evaluar_tablero.sv | 124 ++++++++++++
 tb/tb_evaluar_tablero.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tablero_pkg.sv
// Shared constants for the tic-tac-toe board evaluator: cell codes, the
// eight winning lines as cell indices, and the scan FSM state type.
package tablero_pkg;

  localparam int NUM_LINES = 8;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P0    = 2'b01;
  localparam logic [1:0] CELL_P1    = 2'b10;
  localparam logic [1:0] CELL_BAD   = 2'b11;

  localparam logic [2:0] LAST_LINE = 3'(NUM_LINES - 1);
  localparam logic [1:0] LAST_IDX  = 2'd2;

  // Rows, then columns, then main diagonal, then anti-diagonal (row-major cells)
  localparam logic [3:0] LINE_TABLE [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic is_player(input logic [1:0] code);
    return (code == CELL_P0) || (code == CELL_P1);
  endfunction

endpackage

// File: rtl/tablero_line_rom.sv
// Combinational lookup from (line, position in line) to board cell index.
module tablero_line_rom
  import tablero_pkg::*;
(
  input  logic [2:0] i_line,
  input  logic [1:0] i_idx,
  output logic [3:0] o_cell
);

  always_comb begin
    o_cell = 4'd0;
    if (i_idx <= LAST_IDX) begin
      o_cell = LINE_TABLE[i_line][i_idx];
    end
  end

endmodule

// File: rtl/evaluar_tablero.sv
// Sequential board evaluator: walks the eight lines one cell per cycle and
// reports winner, winning line or draw with a one-cycle done pulse.
module evaluar_tablero
  import tablero_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_evaluate,
  output logic [3:0] o_rd_addr,
  input  logic [1:0] i_rd_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_winner,
  output logic [2:0] o_win_line,
  output logic       o_draw
);

  state_t     r_state, w_state_next;
  logic [2:0] r_line;
  logic [1:0] r_idx;
  logic [1:0] r_a, r_b;
  logic [8:0] r_mask;
  logic [3:0] r_last_addr;
  logic [1:0] r_winner;
  logic [2:0] r_win_line;
  logic       r_draw;
  logic       r_done;

  logic [3:0] w_cell;
  logic [8:0] w_hit;
  logic [8:0] w_mask_now;
  logic       w_line_win;
  logic       w_last;

  tablero_line_rom u_rom (
    .i_line (r_line),
    .i_idx  (r_idx),
    .o_cell (w_cell)
  );

  assign w_hit      = (i_rd_data != CELL_EMPTY) ? (9'd1 << w_cell) : 9'd0;
  assign w_mask_now = r_mask | w_hit;
  assign w_line_win = (r_idx == LAST_IDX) && (r_a == r_b) && (r_b == i_rd_data)
                      && is_player(i_rd_data);
  assign w_last     = (r_idx == LAST_IDX) && (w_line_win || (r_line == LAST_LINE));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (i_evaluate) w_state_next = SCAN;
      SCAN: if (w_last)     w_state_next = IDLE;
      default:              w_state_next = IDLE;
    endcase
  end

  // Address is live from the ROM while scanning and frozen at the last read in IDLE
  always_comb begin
    o_busy    = (r_state == SCAN);
    o_rd_addr = (r_state == SCAN) ? w_cell : r_last_addr;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_line      <= 3'd0;
      r_idx       <= 2'd0;
      r_a         <= CELL_EMPTY;
      r_b         <= CELL_EMPTY;
      r_mask      <= 9'd0;
      r_last_addr <= 4'd0;
      r_winner    <= CELL_EMPTY;
      r_win_line  <= 3'd0;
      r_draw      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_evaluate) begin
          r_line     <= 3'd0;
          r_idx      <= 2'd0;
          r_mask     <= 9'd0;
          r_winner   <= CELL_EMPTY;
          r_win_line <= 3'd0;
          r_draw     <= 1'b0;
        end
      end else begin
        r_mask      <= w_mask_now;
        r_last_addr <= w_cell;
        if (r_idx == 2'd0) r_a <= i_rd_data;
        if (r_idx == 2'd1) r_b <= i_rd_data;
        if (w_last) begin
          r_done <= 1'b1;
          if (w_line_win) begin
            r_winner   <= i_rd_data;
            r_win_line <= r_line;
            r_draw     <= 1'b0;
          end else begin
            r_winner   <= CELL_EMPTY;
            r_win_line <= 3'd0;
            r_draw     <= &w_mask_now;
          end
        end else if (r_idx == LAST_IDX) begin
          r_idx  <= 2'd0;
          r_line <= (r_line == LAST_LINE) ? LAST_LINE : r_line + 3'd1;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_winner   = r_winner;
  assign o_win_line = r_win_line;
  assign o_draw     = r_draw;

endmodule

// File: tb/tb_evaluar_tablero.sv
// Self-checking bench for evaluar_tablero: directed and random boards
// compared cycle by cycle against a rule-level game model.
module tb_evaluar_tablero;

  logic       clk = 1'b0;
  logic       rst;
  logic       evaluate;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic [2:0] win_line;
  logic       draw;

  logic [1:0] board [9];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb rd_data = (rd_addr < 4'd9) ? board[rd_addr] : 2'b00;

  evaluar_tablero dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_evaluate (evaluate),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_winner   (winner),
    .o_win_line (win_line),
    .o_draw     (draw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cell at position i of line k, derived from the board geometry
  function automatic int cell_of(input int k, input int i);
    if (k < 3) return 3 * k + i;
    if (k < 6) return (k - 3) + 3 * i;
    if (k == 6) return 4 * i;
    return 2 + 2 * i;
  endfunction

  // Game rules: first winning line in scan order decides; otherwise draw iff board full
  task automatic model(output int lat, output logic [1:0] w, output int ln, output bit dr);
    bit found = 0;
    lat = 24; w = 2'b00; ln = 0; dr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] a, b, c;
      a = board[cell_of(k, 0)];
      b = board[cell_of(k, 1)];
      c = board[cell_of(k, 2)];
      if (!found && a == b && b == c && (a == 2'b01 || a == 2'b10)) begin
        found = 1; lat = 3 * k + 3; w = a; ln = k; dr = 1'b0;
      end
    end
    if (!found) begin
      for (int j = 0; j < 9; j++) if (board[j] == 2'b00) dr = 1'b0;
    end
  endtask

  task automatic set_board(input logic [17:0] packed_cells);
    for (int j = 0; j < 9; j++) board[j] = packed_cells[2*(8-j) +: 2];
  endtask

  // One evaluation; optional stray evaluate pulse during the scan
  task automatic run_eval(input string name, input int second_pulse_at);
    int lat; logic [1:0] w; int ln; bit dr; int last;
    model(lat, w, ln, dr);
    @(negedge clk) evaluate = 1'b1;
    @(negedge clk) evaluate = 1'b0;
    for (int r = 0; r <= lat; r++) begin
      if (r > 0) @(negedge clk);
      if (r < lat) begin
        check({name, ".busy"}, 32'(busy), 32'd1);
        check({name, ".done_early"}, 32'(done), 32'd0);
        check({name, ".rd_addr"}, 32'(rd_addr), 32'(cell_of(r / 3, r % 3)));
        if (r == 0) begin
          check({name, ".winner_clr"}, 32'(winner), 32'd0);
          check({name, ".draw_clr"}, 32'(draw), 32'd0);
          check({name, ".line_clr"}, 32'(win_line), 32'd0);
        end
      end else begin
        check({name, ".done"}, 32'(done), 32'd1);
        check({name, ".busy_end"}, 32'(busy), 32'd0);
        check({name, ".winner"}, 32'(winner), 32'(w));
        check({name, ".win_line"}, 32'(win_line), 32'(ln));
        check({name, ".draw"}, 32'(draw), 32'(dr));
      end
      evaluate = (r == second_pulse_at) ? 1'b1 : 1'b0;
    end
    evaluate = 1'b0;
    last = cell_of((lat - 1) / 3, (lat - 1) % 3);
    repeat (3) begin
      @(negedge clk);
      check({name, ".done_once"}, 32'(done), 32'd0);
      check({name, ".idle"}, 32'(busy), 32'd0);
      check({name, ".winner_hold"}, 32'(winner), 32'(w));
      check({name, ".draw_hold"}, 32'(draw), 32'(dr));
      check({name, ".addr_hold"}, 32'(rd_addr), 32'(last));
    end
    $display("eval %s: lat=%0d winner=%0d line=%0d draw=%0d", name, lat, w, ln, dr);
  endtask

  initial begin
    rst = 1'b1;
    evaluate = 1'b0;
    for (int j = 0; j < 9; j++) board[j] = 2'b00;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.winner", 32'(winner), 32'd0);
    check("rst.win_line", 32'(win_line), 32'd0);
    check("rst.draw", 32'(draw), 32'd0);
    check("rst.rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    set_board({2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    run_eval("row0", -1);
    set_board({2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01});
    run_eval("anti", -1);
    set_board({2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01});
    run_eval("draw", -1);
    set_board(18'd0);
    run_eval("empty", 5);
    set_board({2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00});
    run_eval("bad", -1);

    // evaluate held high: second scan starts in the first IDLE cycle after done
    set_board({2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    @(negedge clk) evaluate = 1'b1;
    for (int r = 0; r <= 7; r++) begin
      @(negedge clk);
      if (r == 3 || r == 7) begin
        check("hold.done", 32'(done), 32'd1);
        check("hold.winner", 32'(winner), 32'd1);
      end else begin
        check("hold.busy", 32'(busy), 32'd1);
        check("hold.nodone", 32'(done), 32'd0);
      end
      if (r == 4) evaluate = 1'b0;
    end
    @(negedge clk);
    check("hold.idle", 32'(busy), 32'd0);
    $display("eval hold: back-to-back scans");

    // Reset mid-scan aborts without a done pulse
    set_board(18'd0);
    @(negedge clk) evaluate = 1'b1;
    @(negedge clk) evaluate = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.winner", 32'(winner), 32'd0);
    check("abort.draw", 32'(draw), 32'd0);
    check("abort.rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      check("abort.nodone", 32'(done), 32'd0);
    end
    $display("eval abort: reset during scan");
    set_board({2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00});
    run_eval("after_rst", -1);

    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < 9; j++) begin
        if (t % 2 == 0) board[j] = 2'($urandom_range(0, 3));
        else            board[j] = 2'($urandom_range(1, 2));
      end
      run_eval($sformatf("rand%0d", t), (t % 5 == 0) ? 1 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
